pipeline_controller: RTL
========================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum data-memory wait cycles before the error state.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-low reset; reset==0 at a posedge resets the block.
REQ-004 rs1D, rs2D  input  5 each  source registers in decode.
REQ-005 rs1E, rs2E, rdE  input  5 each  source and destination registers in execute.
REQ-006 rdM, rdW  input  5 each  destination registers in memory and writeback.
REQ-007 reg_writeM, reg_writeW  input  1 each  register-write enables in memory and writeback.
REQ-008 load_e  input  1  execute-stage instruction is a load (result_src == 01).
REQ-009 pc_srcE  input  1  taken branch or jump resolved in execute.
REQ-010 mem_accessM  input  1  memory-stage instruction accesses data memory.
REQ-011 dmem_ready  input  1  data memory completes the access this cycle.
REQ-012 forward_ae, forward_be  output  2 each  ALU operand select: 00 register file, 01 writeback result, 10 memory alu_result.
REQ-013 stall_f, stall_d, stall_e, stall_m  output  1 each  hold the PC and the IF/ID, ID/EX and EX/MEM registers.
REQ-014 flush_d, flush_e, flush_w  output  1 each  clear IF/ID and ID/EX, and drive the MEM/WB register's reset input (bubble into writeback).
REQ-015 mem_error  output  1  sticky data-memory timeout flag.
REQ-016 stall_count  output  32  performance count of cycles with stall_f==1.

Function
REQ-017 Forwarding is combinational: forward_ae=10 if reg_writeM && rdM!=0 && rdM==rs1E; else 01 if reg_writeW && rdW!=0 && rdW==rs1E; else 00. forward_be uses rs2E the same way.
REQ-018 Memory takes priority over writeback forwarding when both match.
REQ-019 lw_stall = load_e && rdE!=0 && (rdE==rs1D || rdE==rs2D), combinational.
REQ-020 mem_stall = (state==RUN && mem_accessM && !dmem_ready) || (state==MEM_WAIT && !dmem_ready) || state==ERROR.
REQ-021 Action priority 1, mem_stall: stall_f=stall_d=stall_e=stall_m=1, flush_w=1, flush_d=flush_e=0.
REQ-022 Action priority 2, pc_srcE with no mem_stall: flush_d=flush_e=1, all stalls 0; lw_stall ignored because the decode instruction is discarded.
REQ-023 Action priority 3, lw_stall only: stall_f=stall_d=1, flush_e=1, all other controls 0.
REQ-024 With no condition active, all stall and flush outputs are 0.
REQ-025 The FSM has three states: RUN, MEM_WAIT, ERROR, with a 5-bit counter wait_cnt.
REQ-026 RUN, mem_accessM && !dmem_ready: go to MEM_WAIT, wait_cnt<=1.
REQ-027 RUN, otherwise: stay in RUN.
REQ-028 MEM_WAIT, dmem_ready: go to RUN, wait_cnt<=0; the stalls release in the same cycle as ready.
REQ-029 MEM_WAIT, !dmem_ready and wait_cnt==TIMEOUT: go to ERROR.
REQ-030 MEM_WAIT, otherwise: wait_cnt<=wait_cnt+1.
REQ-031 ERROR is absorbing until reset; mem_error=1 is registered and asserts the cycle after entering ERROR.
REQ-032 A dmem_ready that arrives while in ERROR is ignored.
REQ-033 stall_count increments by 1 at each posedge where stall_f==1, wraps from FFFFFFFF to 0, and has no saturation.

Reset
REQ-034 reset==0 at a posedge sets state=RUN, wait_cnt=0, mem_error=0, stall_count=0.
REQ-035 Reset mid-wait or in ERROR has the same effect; the outputs follow REQ-017 to REQ-024 from the reset values on the next cycle.
REQ-036 While reset==0, the combinational outputs still evaluate from the inputs with state=RUN.

Verification
REQ-037 Forward: rdM=5, reg_writeM=1, rdW=5, reg_writeW=1, rs1E=5 -> forward_ae=10; with rdM=0 instead -> forward_ae=01.
REQ-038 Load-use: load_e=1, rdE=7, rs2D=7 -> stall_f=stall_d=flush_e=1 for one cycle; with rdE=0 -> no stall.
REQ-039 Branch plus load-use: pc_srcE=1 together with lw_stall -> flush_d=flush_e=1, stall_f=0.
REQ-040 Memory wait: mem_accessM=1 with dmem_ready low for 3 cycles then high -> 3 cycles of all stalls plus flush_w; release on the ready cycle; stall_count=3.
REQ-041 Timeout: TIMEOUT=15 with dmem_ready never asserted -> ERROR after 16 stalled cycles, mem_error=1 one cycle later, stalls held; reset==0 then clears everything.
REQ-042 Wrap: preload stall_count=FFFFFFFF (force), one stall cycle -> stall_count=0.

Source files
------------

// File: rtl/pipeline_controller.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use interlock,
// branch flush, and data-memory wait handling with a timeout error state.
module pipeline_controller #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1D,
    input  logic [4:0]  rs2D,
    input  logic [4:0]  rs1E,
    input  logic [4:0]  rs2E,
    input  logic [4:0]  rdE,
    input  logic [4:0]  rdM,
    input  logic [4:0]  rdW,
    input  logic        reg_writeM,
    input  logic        reg_writeW,
    input  logic        load_e,
    input  logic        pc_srcE,
    input  logic        mem_accessM,
    input  logic        dmem_ready,
    output logic [1:0]  forward_ae,
    output logic [1:0]  forward_be,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        flush_d,
    output logic        flush_e,
    output logic        flush_w,
    output logic        mem_error,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    localparam logic [4:0] TIMEOUT_CNT = TIMEOUT[4:0];

    state_t     state, state_next, state_eff;
    logic [4:0] wait_cnt, wait_cnt_next;
    logic       lw_stall, mem_stall;

    // Memory-stage result wins over writeback when both hold the register.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (reg_writeM && rdM != 5'd0 && rdM == rs)
            return 2'b10;
        else if (reg_writeW && rdW != 5'd0 && rdW == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign forward_ae = fwd_sel(rs1E);
    assign forward_be = fwd_sel(rs2E);

    // Hazard decode sees RUN while reset is held, whatever the register holds.
    assign state_eff = reset ? state : RUN;

    assign lw_stall  = load_e && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D);
    assign mem_stall = (state_eff == RUN && mem_accessM && !dmem_ready)
                    || (state_eff == MEM_WAIT && !dmem_ready)
                    || (state_eff == ERROR);

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (pc_srcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            RUN: begin
                if (mem_accessM && !dmem_ready) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = 5'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_next    = RUN;
                    wait_cnt_next = 5'd0;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    state_next = ERROR;
                end else begin
                    wait_cnt_next = wait_cnt + 5'd1;
                end
            end
            ERROR: state_next = ERROR;
            default: begin
                state_next    = RUN;
                wait_cnt_next = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= 5'd0;
            mem_error   <= 1'b0;
            stall_count <= 32'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state == ERROR)
                mem_error <= 1'b1;
            if (stall_f)
                stall_count <= stall_count + 32'd1;
        end
    end

endmodule
